// File: rtl/snake_body_tracker.sv
// Snake segment store and collision engine: walls, self and apple checks per move pulse.
// Move takes `length` cycles (L-1 scan + 1 update); step_i ignored while busy or dead.
module snake_body_tracker #(
    parameter int GRID_W   = 16,
    parameter int GRID_H   = 12,
    parameter int MAX_LEN  = 32,
    parameter int INIT_LEN = 3,
    localparam int LW = $clog2(MAX_LEN + 1),
    localparam int IW = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step_i,
    input  logic [1:0]    dir_i,
    input  logic [3:0]    apple_x_i,
    input  logic [3:0]    apple_y_i,
    input  logic          restart_i,
    output logic [3:0]    head_x,
    output logic [3:0]    head_y,
    output logic [LW-1:0] length,
    output logic          goodColl,
    output logic          badColl,
    output logic          busy,
    output logic          dead
);

    typedef enum logic [1:0] {IDLE, SCAN, UPDATE, DEAD} state_t;

    localparam logic [1:0] DIR_UP = 2'd0, DIR_DOWN = 2'd1, DIR_LEFT = 2'd2, DIR_RIGHT = 2'd3;

    state_t        r_state, w_state_nxt;
    logic [3:0]    r_seg_x [MAX_LEN];
    logic [3:0]    r_seg_y [MAX_LEN];
    logic [LW-1:0] r_len;
    logic [IW-1:0] r_idx;
    logic [1:0]    r_cur_dir;
    logic [3:0]    r_nxt_x, r_nxt_y;
    logic          r_good, r_bad;

    logic [1:0]    w_eff_dir;
    logic [4:0]    w_nx, w_ny;
    logic          w_wall, w_hit, w_last, w_eat;

    // Bit 0 flips between opposite directions (up/down, left/right).
    assign w_eff_dir = (dir_i == (r_cur_dir ^ 2'b01)) ? r_cur_dir : dir_i;

    always_comb begin
        w_nx = {1'b0, r_seg_x[0]};
        w_ny = {1'b0, r_seg_y[0]};
        case (w_eff_dir)
            DIR_UP:    w_ny = {1'b0, r_seg_y[0]} - 5'd1;
            DIR_DOWN:  w_ny = {1'b0, r_seg_y[0]} + 5'd1;
            DIR_LEFT:  w_nx = {1'b0, r_seg_x[0]} - 5'd1;
            default:   w_nx = {1'b0, r_seg_x[0]} + 5'd1;
        endcase
    end

    // -1 wraps to 31 in 5 bits, so one unsigned compare covers both edges.
    assign w_wall = (w_nx >= 5'(GRID_W)) || (w_ny >= 5'(GRID_H));
    assign w_hit  = (r_nxt_x == r_seg_x[r_idx]) && (r_nxt_y == r_seg_y[r_idx]);
    assign w_last = (LW'(r_idx) == r_len - LW'(2));
    assign w_eat  = (r_nxt_x == apple_x_i) && (r_nxt_y == apple_y_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (step_i) w_state_nxt = w_wall ? DEAD : SCAN;
            SCAN:    if (w_hit) w_state_nxt = DEAD;
                     else if (w_last) w_state_nxt = UPDATE;
            UPDATE:  w_state_nxt = IDLE;
            default: w_state_nxt = DEAD;
        endcase
        if (restart_i) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_seg_x[i] <= (i < INIT_LEN) ? 4'(GRID_W / 2 - i) : 4'd0;
                r_seg_y[i] <= (i < INIT_LEN) ? 4'(GRID_H / 2) : 4'd0;
            end
            r_len     <= LW'(INIT_LEN);
            r_idx     <= '0;
            r_cur_dir <= DIR_RIGHT;
            r_nxt_x   <= '0;
            r_nxt_y   <= '0;
            r_good    <= 1'b0;
            r_bad     <= 1'b0;
        end else if (restart_i) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_seg_x[i] <= (i < INIT_LEN) ? 4'(GRID_W / 2 - i) : 4'd0;
                r_seg_y[i] <= (i < INIT_LEN) ? 4'(GRID_H / 2) : 4'd0;
            end
            r_len     <= LW'(INIT_LEN);
            r_idx     <= '0;
            r_cur_dir <= DIR_RIGHT;
            r_good    <= 1'b0;
            r_bad     <= 1'b0;
        end else begin
            r_good <= 1'b0;
            r_bad  <= 1'b0;
            case (r_state)
                IDLE: if (step_i) begin
                    r_cur_dir <= w_eff_dir;
                    r_nxt_x   <= w_nx[3:0];
                    r_nxt_y   <= w_ny[3:0];
                    r_idx     <= '0;
                    r_bad     <= w_wall;
                end
                SCAN: begin
                    if (w_hit) r_bad <= 1'b1;
                    else       r_idx <= r_idx + IW'(1);
                end
                UPDATE: begin
                    // The shift keeps the old tail in storage, so growing is just a length bump.
                    for (int i = 1; i < MAX_LEN; i++) begin
                        r_seg_x[i] <= r_seg_x[i-1];
                        r_seg_y[i] <= r_seg_y[i-1];
                    end
                    r_seg_x[0] <= r_nxt_x;
                    r_seg_y[0] <= r_nxt_y;
                    if (w_eat) begin
                        r_good <= 1'b1;
                        if (r_len < LW'(MAX_LEN)) r_len <= r_len + LW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_x   = r_seg_x[0];
    assign head_y   = r_seg_y[0];
    assign length   = r_len;
    assign goodColl = r_good;
    assign badColl  = r_bad;
    assign busy     = (r_state == SCAN) || (r_state == UPDATE);
    assign dead     = (r_state == DEAD);

endmodule

// File: tb/tb_snake_body_tracker.sv
// Directed bench for snake_body_tracker; a MAX_LEN=4 copy shares the stimulus for the full-length case.
module tb_snake_body_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       step_i = 1'b0;
    logic [1:0] dir_i = 2'd3;
    logic [3:0] apple_x_i = 4'd0, apple_y_i = 4'd0;
    logic       restart_i = 1'b0;

    logic [3:0] head_x, head_y, head_x2, head_y2;
    logic [5:0] length;
    logic [2:0] length2;
    logic       goodColl, badColl, busy, dead;
    logic       goodColl2, badColl2, busy2, dead2;

    int n_chk = 0, n_fail = 0;
    int w_busy, w_good, w_bad, w_bad_at, w_both, w_good2;

    always #5 clk = ~clk;

    snake_body_tracker dut (
        .clk(clk), .rst(rst), .step_i(step_i), .dir_i(dir_i),
        .apple_x_i(apple_x_i), .apple_y_i(apple_y_i), .restart_i(restart_i),
        .head_x(head_x), .head_y(head_y), .length(length),
        .goodColl(goodColl), .badColl(badColl), .busy(busy), .dead(dead)
    );

    snake_body_tracker #(.MAX_LEN(4)) dut4 (
        .clk(clk), .rst(rst), .step_i(step_i), .dir_i(dir_i),
        .apple_x_i(apple_x_i), .apple_y_i(apple_y_i), .restart_i(restart_i),
        .head_x(head_x2), .head_y(head_y2), .length(length2),
        .goodColl(goodColl2), .badColl(badColl2), .busy(busy2), .dead(dead2)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; step_i = 1'b0; restart_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Pulses step_i, then watches 8 cycles starting with the one after the sampling edge.
    task automatic do_step(input logic [1:0] d);
        dir_i = d;
        step_i = 1'b1;
        @(negedge clk);
        step_i = 1'b0;
        w_busy = 0; w_good = 0; w_bad = 0; w_bad_at = -1; w_both = 0; w_good2 = 0;
        for (int k = 0; k < 8; k++) begin
            if (busy) w_busy++;
            if (goodColl) w_good++;
            if (goodColl2) w_good2++;
            if (goodColl && badColl) w_both++;
            if (badColl) begin
                w_bad++;
                if (w_bad_at < 0) w_bad_at = k;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        // 1: reset state, walk right into the wall, then DEAD ignores steps, then rst
        do_reset();
        chk("rst_head_x", head_x, 8);
        chk("rst_head_y", head_y, 6);
        chk("rst_len", length, 3);
        chk("rst_busy", busy, 0);
        chk("rst_dead", dead, 0);
        chk("rst_pulses", goodColl + badColl, 0);
        for (int s = 0; s < 7; s++) begin
            do_step(2'd3);
            chk("walk_busy_cycles", w_busy, 3);
            chk("walk_no_pulse", w_good + w_bad, 0);
        end
        chk("walk_head_x", head_x, 15);
        chk("walk_head_y", head_y, 6);
        chk("walk_len", length, 3);
        do_step(2'd3);
        chk("wall_bad_count", w_bad, 1);
        chk("wall_bad_cycle", w_bad_at, 0);
        chk("wall_busy", w_busy, 0);
        chk("wall_dead", dead, 1);
        do_step(2'd0);
        chk("dead_no_pulse", w_bad + w_good + w_busy, 0);
        chk("dead_head_x", head_x, 15);
        chk("dead_still", dead, 1);
        do_reset();
        chk("rerst_head_x", head_x, 8);
        chk("rerst_len", length, 3);
        chk("rerst_dead", dead, 0);

        // 2: eat one apple
        apple_x_i = 4'd9; apple_y_i = 4'd6;
        do_step(2'd3);
        chk("eat_busy", w_busy, 3);
        chk("eat_good", w_good, 1);
        chk("eat_bad", w_bad, 0);
        chk("eat_head_x", head_x, 9);
        chk("eat_len", length, 4);
        chk("seg1_x", dut.r_seg_x[1], 8);
        chk("seg2_x", dut.r_seg_x[2], 7);
        chk("seg3_x", dut.r_seg_x[3], 6);
        chk("seg3_y", dut.r_seg_y[3], 6);

        // 3: reversal request is replaced by the current direction
        do_reset();
        apple_x_i = 4'd0; apple_y_i = 4'd0;
        do_step(2'd2);
        chk("rev_head_x", head_x, 9);
        chk("rev_head_y", head_y, 6);
        chk("rev_bad", w_bad, 0);

        // 4 and 6: grow to 5 (MAX_LEN=4 copy saturates at 4), then coil into the body
        do_reset();
        apple_x_i = 4'd9; apple_y_i = 4'd6;
        do_step(2'd3);
        apple_x_i = 4'd10; apple_y_i = 4'd6;
        do_step(2'd3);
        chk("grow_len", length, 5);
        chk("grow_busy", w_busy, 4);
        chk("full_good", w_good2, 1);
        chk("full_len", length2, 4);
        apple_x_i = 4'd0; apple_y_i = 4'd0;
        do_step(2'd0);
        chk("up_head_y", head_y, 5);
        chk("up_busy", w_busy, 5);
        do_step(2'd2);
        chk("left_head_x", head_x, 9);
        do_step(2'd1);
        chk("self_bad_count", w_bad, 1);
        chk("self_bad_cycle", w_bad_at, 4);
        chk("self_busy", w_busy, 4);
        chk("self_no_good", w_good, 0);
        chk("self_len", length, 5);
        chk("self_head_x", head_x, 9);
        chk("self_head_y", head_y, 5);
        chk("self_dead", dead, 1);
        chk("never_both", w_both, 0);

        // 5: step while busy is dropped; restart mid-scan
        do_reset();
        dir_i = 2'd3;
        step_i = 1'b1;
        @(negedge clk);
        step_i = 1'b1;
        chk("busy_after_step", busy, 1);
        @(negedge clk);
        step_i = 1'b0;
        repeat (10) @(negedge clk);
        chk("one_move_x", head_x, 9);
        chk("one_move_busy", busy, 0);
        step_i = 1'b1;
        @(negedge clk);
        step_i = 1'b0;
        chk("scan_busy", busy, 1);
        restart_i = 1'b1;
        @(negedge clk);
        restart_i = 1'b0;
        chk("restart_head_x", head_x, 8);
        chk("restart_head_y", head_y, 6);
        chk("restart_len", length, 3);
        chk("restart_busy", busy, 0);
        w_good = 0; w_bad = 0;
        for (int k = 0; k < 5; k++) begin
            w_good += goodColl;
            w_bad  += badColl;
            @(negedge clk);
        end
        chk("restart_no_pulse", w_good + w_bad, 0);
        chk("restart_hold_x", head_x, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not end, expected completion");
        $fatal(1);
    end

endmodule
